// File: rtl/data_bus_responder.sv
// data_bus_responder: zero-wait data memory target with word RAM, LED register, cycle counter and TX byte FIFO
module data_bus_responder #(
    parameter int RAM_WORDS  = 256,
    parameter int LED_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [31:0]      addr,
    input  logic [31:0]      wr_data,
    input  logic             wr_ena,
    output logic [31:0]      rd_data,
    output logic [LED_W-1:0] leds,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             bus_err
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [63:0]   cnt, snap;
    logic [PW-1:0] rp, wp;
    logic [CW-1:0] count;
    logic [5:0]    off;
    logic [31:0]   status;
    logic overflow, ram_sel, mmio_sel, mmio_wr, empty, full, push_req, push, pop;
    assign ram_sel  = addr < 32'(RAM_WORDS * 4);
    assign mmio_sel = addr[31:28] == 4'hF;
    assign mmio_wr  = wr_ena && mmio_sel;
    assign off      = addr[7:2];
    assign empty    = count == '0;
    assign full     = count == CW'(FIFO_DEPTH);
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo[rp];
    assign pop      = tx_valid && tx_ready;
    assign push_req = mmio_wr && off == 6'h04;
    // a pop on the same edge frees the slot a full-FIFO push needs
    assign push     = push_req && (!full || pop);
    assign status   = {24'h0, 4'(count), 1'b0, overflow, full, empty};
    always_comb
        rd_data = ram_sel ? ram[addr[AW+1:2]] :
                  !mmio_sel ? 32'h0 :
                  off == 6'h00 ? 32'(leds) :
                  off == 6'h02 ? snap[31:0] :
                  off == 6'h03 ? snap[63:32] :
                  off == 6'h05 ? status : 32'h0;
    always_ff @(posedge clk) begin
        if (wr_ena && ram_sel) ram[addr[AW+1:2]] <= wr_data;
        if (push) fifo[wp] <= wr_data[7:0];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            leds     <= '0;
            cnt      <= '0;
            snap     <= '0;
            rp       <= '0;
            wp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if (mmio_wr && off == 6'h00) leds <= wr_data[LED_W-1:0];
            cnt <= (mmio_wr && off == 6'h01 && wr_data[1]) ? '0 : cnt + 64'(ena);
            if (mmio_wr && off == 6'h01 && wr_data[0]) snap <= cnt;
            if (pop) rp <= rp + PW'(1);
            if (push) wp <= wp + PW'(1);
            count    <= count + CW'(push) - CW'(pop);
            overflow <= (push_req && full && !pop) || (overflow && !(mmio_wr && off == 6'h05 && wr_data[2]));
            bus_err  <= bus_err || (wr_ena && !ram_sel && !mmio_sel);
        end
endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Target side of the core's single-cycle data memory port: answers `data_mem_addr` / `data_mem_wr_data` / `data_mem_wr_ena` with `data_mem_rd_data`.
- Holds a word RAM and a small MMIO peripheral set: LED register, 64-bit cycle counter with snapshot, and an 8-deep byte TX FIFO drained over a valid/ready stream.
- Reads take zero wait states, because the core captures read data at the end of its memory stage.

Parameters:
- RAM_WORDS, 256, number of 32-bit RAM words; must be a power of 2.
- LED_W, 8, width of the LED output register.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, max 15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ena  input  1  cycle counter increment enable; gates nothing else.
- addr  input  32  byte address from the core (`data_mem_addr`); bits [1:0] are ignored.
- wr_data  input  32  store data from the core.
- wr_ena  input  1  store strobe; writes commit on the rising edge.
- rd_data  output  32  read data; combinational from `addr` and the current state.
- leds  output  LED_W  LED register contents.
- tx_data  output  8  head-of-FIFO byte.
- tx_valid  output  1  FIFO not empty.
- tx_ready  input  1  sink accepts `tx_data` when `tx_valid` and `tx_ready` are both high at the clock edge.
- bus_err  output  1  sticky flag: a store was made to an unmapped address.

Behaviour:
- Address decode:
  - RAM when `addr < RAM_WORDS*4`, indexed by `addr[log2(RAM_WORDS)+1:2]`.
  - MMIO when `addr[31:28] == 4'hF`, selected by offset `addr[7:0]`; `addr[27:8]` are ignored.
  - Everything else is unmapped.
- MMIO map:
  - 0x00 LED: read/write, low LED_W bits; reads zero-extend.
  - 0x04 CNT_CTRL: write bit0 = snapshot the counter into SNAP; write bit1 = clear the counter. Reads return 0.
  - 0x08 CNT_LO: read-only, SNAP[31:0].
  - 0x0C CNT_HI: read-only, SNAP[63:32].
  - 0x10 TX_DATA: a write pushes `wr_data[7:0]`. Reads return 0.
  - 0x14 TX_STATUS: read bit0 = empty, bit1 = full, bit2 = overflow, bits[7:4] = count, other bits 0. Writing bit2 = 1 clears overflow.
- Reads have no side effects. The core drives `addr` with ALU results on non-memory instructions, so state may only change when `wr_ena` = 1.
- Read timing:
  - `rd_data` is valid in the same cycle as `addr`.
  - A read and a write to the same location in one cycle return the old value.
  - Unmapped or write-only reads return 0.
- RAM:
  - Contents are not reset and are X until written.
  - A write on an edge is visible to the combinational read in the next cycle.
- Writes to read-only or unmapped offsets are ignored. Any `wr_ena` to an unmapped address sets `bus_err` on the next edge; it stays set until reset.
- Cycle counter (64 bits):
  - Adds 1 per edge while `ena` = 1 and wraps from 2^64-1 to 0.
  - A clear write forces 0 on that edge and overrides the increment.
  - Snapshot and clear in the same write: SNAP captures the pre-edge counter value.
- TX FIFO:
  - Circular buffer with read pointer, write pointer and count.
  - Pop occurs when `tx_valid && tx_ready`. `tx_data` is the head entry and holds stable while `tx_valid && !tx_ready`.
  - A push while full with no pop in the same cycle is dropped: data is discarded, count is unchanged, overflow is set (sticky).
  - Push while full with a pop in the same cycle: the push is accepted and count is unchanged.
  - Push and pop together while empty: the pop is not possible, so the push is accepted and count becomes 1.
  - Latency: a byte pushed on edge N gives `tx_valid` = 1 after edge N.
- Reset (async, also mid-transfer): `leds` = 0, counter = 0, SNAP = 0, FIFO emptied (pointers and count 0), `tx_valid` = 0 immediately, overflow = 0, `bus_err` = 0. RAM is untouched. `tx_data` = 0 while empty.

Test Plan:
- RAM round-trip: store 0x12345678 to 0x10, then load 0x10 on the next cycle -> `rd_data` = 0x12345678. Load 0x13 -> same word.
- LED and errors: store 0xFFFFFFA5 to 0xF0000000 -> `leds` = 0xA5, readback = 0x000000A5. Store to 0x80000000 -> `bus_err` = 1 after the edge, LED unchanged.
- Counter:
  - Hold `ena` high for 10 cycles after reset, then write 0x1 to CNT_CTRL -> CNT_LO = 10, CNT_HI = 0.
  - Write 0x3 -> SNAP holds the pre-clear value and the counter restarts from 0.
- Counter carry: run the counter past 0xFFFFFFFF, then snapshot -> CNT_HI = 1.
- FIFO fill with `tx_ready` = 0:
  - Push 0x41..0x48 -> STATUS = 0x82 (count 8, full).
  - 9th push 0x49 -> STATUS = 0x86 (count 8, full, overflow), byte dropped.
  - Raise `tx_ready` -> sink receives 0x41..0x48 in order over 8 cycles, then `tx_valid` = 0.
- Full boundary:
  - With the FIFO full and `tx_ready` = 1, push 0x5A in the same cycle as a pop -> count stays 8, no overflow, 0x5A delivered last.
  - Assert `rst` mid-drain -> `tx_valid` drops without waiting for a clock edge and STATUS = 0x01.
